// File: rtl/bch_encoder_p16.sv
`default_nettype none
// ============================================================================
//  Module      : bch_encoder_p16
//  Description : Systematic BCH encoder, 16-bit word datapath. Passes
//                MSG_WORDS message words through unchanged, then appends
//                13 parity words (208-bit remainder of m(x)*x^208 mod g(x)).
//                Single registered output slot with valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module bch_encoder_p16 #(
    parameter int MSG_WORDS = 496
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [207:0] g_poly,
    input  logic [15:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [15:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last
);

    localparam int PAR_WORDS = 13;
    localparam int CNT_W     = $clog2(MSG_WORDS + PAR_WORDS + 1);

    localparam logic [CNT_W-1:0] LAST_MSG_IDX = CNT_W'(MSG_WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_PAR_IDX = CNT_W'(PAR_WORDS - 1);
    localparam logic [CNT_W-1:0] PAR_DONE     = CNT_W'(PAR_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MSG  = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [207:0]       r;
    logic [CNT_W-1:0]   cnt;

    logic               slot_free;
    logic               transfer;
    logic               last_leaving;
    logic               accept;
    logic               frame_start;
    logic [CNT_W-1:0]   word_idx;
    logic               msg_done;
    logic               par_load;
    logic [207:0]       r_base;
    logic [207:0]       r_next_msg;

    // Sixteen bit-serial LFSR steps, MSB of the word first.
    function automatic logic [207:0] step16(
        input logic [207:0] r_in,
        input logic [15:0]  d,
        input logic [207:0] g
    );
        logic [207:0] acc;
        logic         fb;
        acc = r_in;
        for (int i = 15; i >= 0; i--) begin
            fb  = d[i] ^ acc[207];
            acc = {acc[206:0], 1'b0} ^ (fb ? g : 208'd0);
        end
        return acc;
    endfunction

    // Handshake and control decode.
    always_comb begin
        slot_free    = !out_valid || out_ready;
        transfer     = out_valid && out_ready;
        // The final parity word leaving the slot frees the block for a new
        // frame in the same cycle, so back-to-back frames have no gap.
        last_leaving = (state == PAR) && (cnt == PAR_DONE) && out_last && transfer;
        in_ready     = rst_n && slot_free && ((state != PAR) || last_leaving);
        accept       = in_valid && in_ready;
        // A word accepted outside MSG is always the first word of a frame.
        frame_start  = accept && (state != MSG);
        word_idx     = frame_start ? '0 : cnt;
        msg_done     = accept && (word_idx == LAST_MSG_IDX);
        par_load     = (state == PAR) && slot_free && (cnt != PAR_DONE);
        r_base       = frame_start ? 208'd0 : r;
        r_next_msg   = step16(r_base, in_data, g_poly);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = msg_done ? PAR : MSG;
                end
            end
            MSG: begin
                if (msg_done) begin
                    state_nx = PAR;
                end
            end
            PAR: begin
                if (accept) begin
                    state_nx = msg_done ? PAR : MSG;
                end else if (last_leaving) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Parity register, word counter and output slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r         <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            // Message word passes straight through; remainder absorbs it.
            r         <= r_next_msg;
            cnt       <= msg_done ? '0 : (word_idx + CNT_ONE);
            out_data  <= in_data;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
        end else if (par_load) begin
            // Parity leaves MSB first; shifting clears r by the frame end.
            out_data  <= r[207:192];
            r         <= {r[191:0], 16'h0000};
            cnt       <= cnt + CNT_ONE;
            out_valid <= 1'b1;
            out_last  <= (cnt == LAST_PAR_IDX);
        end else if (transfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (last_leaving) begin
                cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bch_encoder_p16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bch_encoder_p16
//  Description : Directed self-checking bench for bch_encoder_p16 using a
//                4-word instance and a 496-word instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bch_encoder_p16;

    typedef struct {
        logic [15:0] d;
        logic        l;
        int          c;
    } ow_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Instance A: MSG_WORDS = 4
    logic         rst_n_a = 1'b0;
    logic [207:0] g_a = '0;
    logic [15:0]  in_data_a = '0;
    logic         in_valid_a = 1'b0;
    logic         in_ready_a;
    logic [15:0]  out_data_a;
    logic         out_valid_a;
    logic         out_ready_a = 1'b1;
    logic         out_last_a;
    bit           rand_a = 1'b0;

    // Instance B: MSG_WORDS = 496
    logic         rst_n_b = 1'b0;
    logic [207:0] g_b = '0;
    logic [15:0]  in_data_b = '0;
    logic         in_valid_b = 1'b0;
    logic         in_ready_b;
    logic [15:0]  out_data_b;
    logic         out_valid_b;
    logic         out_ready_b = 1'b1;
    logic         out_last_b;

    bch_encoder_p16 #(.MSG_WORDS(4)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .g_poly(g_a),
        .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_last(out_last_a)
    );

    bch_encoder_p16 #(.MSG_WORDS(496)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .g_poly(g_b),
        .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_last(out_last_b)
    );

    ow_t q_a[$];
    ow_t q_b[$];

    // Downstream ready for A: constant 1 or a pseudo-random 50% pattern.
    always @(posedge clk) begin
        #2;
        out_ready_a = rand_a ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output collector for A, including stall stability.
    logic        hold_v = 1'b0;
    logic [15:0] hold_d = '0;
    logic        hold_l = 1'b0;
    always @(negedge clk) begin
        if (hold_v) begin
            checks++;
            assert (out_valid_a === 1'b1 && out_data_a === hold_d && out_last_a === hold_l)
            else begin
                errors++;
                $error("FAIL hold_a got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                       out_valid_a, out_data_a, out_last_a, hold_d, hold_l);
            end
        end
        if (out_valid_a === 1'b1 && out_ready_a === 1'b1)
            q_a.push_back('{d: out_data_a, l: out_last_a, c: cyc});
        hold_v = (out_valid_a === 1'b1) && (out_ready_a === 1'b0) && rst_n_a;
        hold_d = out_data_a;
        hold_l = out_last_a;
    end

    // Output collector for B.
    always @(negedge clk) begin
        if (out_valid_b === 1'b1 && out_ready_b === 1'b1)
            q_b.push_back('{d: out_data_b, l: out_last_b, c: cyc});
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference remainder by polynomial long division of m(x)*x^208.
    function automatic logic [207:0] model_rem(input logic [15:0] m[$], input logic [207:0] g);
        logic [8191:0] v;
        int nb;
        v  = '0;
        nb = m.size() * 16;
        for (int k = 0; k < m.size(); k++)
            v[208 + nb - 1 - 16*k -: 16] = m[k];
        for (int i = nb + 207; i >= 208; i--)
            if (v[i]) v[i -: 209] = v[i -: 209] ^ {1'b1, g};
        return v[207:0];
    endfunction

    function automatic logic [207:0] rand208();
        logic [223:0] t;
        for (int i = 0; i < 7; i++) t[32*i +: 32] = $urandom;
        return t[207:0];
    endfunction

    // Present one word and hold it until accepted (in_valid left high).
    task automatic push(input bit sel, input logic [15:0] d, output int acc_cyc);
        int n;
        logic rdy;
        @(negedge clk);
        if (sel) begin in_data_b = d; in_valid_b = 1'b1; end
        else     begin in_data_a = d; in_valid_a = 1'b1; end
        #1;
        n = 0;
        rdy = sel ? in_ready_b : in_ready_a;
        while (rdy !== 1'b1 && n < 300) begin
            @(negedge clk); #1;
            n++;
            rdy = sel ? in_ready_b : in_ready_a;
        end
        checks++;
        assert (rdy === 1'b1) else begin
            errors++;
            $error("FAIL push_timeout sel=%0d got in_ready=%b exp 1", sel, rdy);
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
    endtask

    task automatic idle(input bit sel);
        if (sel) in_valid_b = 1'b0; else in_valid_a = 1'b0;
    endtask

    task automatic send_frame(input bit sel, input logic [15:0] m[$], output int first_acc);
        int c;
        first_acc = -1;
        for (int k = 0; k < m.size(); k++) begin
            push(sel, m[k], c);
            if (k == 0) first_acc = c;
        end
    endtask

    // Wait for a complete codeword and compare every word and out_last.
    task automatic check_frame(input bit sel, input logic [15:0] m[$], input logic [207:0] par,
                               input string tag, output int c_first, output int c_last);
        logic [15:0] exp_w[$];
        ow_t got[$];
        int n;
        int w;
        n = m.size() + 13;
        exp_w = m;
        for (int k = 0; k < 13; k++) exp_w.push_back(par[207 - 16*k -: 16]);
        w = 0;
        while (((sel ? q_b.size() : q_a.size()) < n) && w < 3000) begin
            @(negedge clk); #1;
            w++;
        end
        if (sel) got = q_b; else got = q_a;
        checks++;
        assert (got.size() >= n) else begin
            errors++;
            $error("FAIL %s_count got %0d exp %0d", tag, got.size(), n);
        end
        c_first = -1;
        c_last  = -1;
        for (int k = 0; k < n && k < got.size(); k++) begin
            checks++;
            assert (got[k].d === exp_w[k]) else begin
                errors++;
                $error("FAIL %s_word%0d got %h exp %h", tag, k, got[k].d, exp_w[k]);
            end
            checks++;
            assert (got[k].l === (k == n - 1)) else begin
                errors++;
                $error("FAIL %s_last%0d got %b exp %b", tag, k, got[k].l, (k == n - 1));
            end
            if (k == 0) c_first = got[k].c;
            c_last = got[k].c;
        end
        for (int k = 0; k < n; k++) begin
            if (sel) begin if (q_b.size() > 0) void'(q_b.pop_front()); end
            else     begin if (q_a.size() > 0) void'(q_a.pop_front()); end
        end
    endtask

    initial begin
        logic [15:0] m[$];
        logic [15:0] m2[$];
        int acc0, acc2, cf, cl, cf2, cl2, dummy;

        // ---------------- Reset state ----------------
        @(negedge clk); @(negedge clk);
        checks++;
        assert (out_valid_a === 1'b0 && out_last_a === 1'b0 && out_data_a === 16'h0000)
        else begin errors++; $error("FAIL reset_outputs got v=%b l=%b d=%h exp 0 0 0000", out_valid_a, out_last_a, out_data_a); end
        checks++;
        assert (in_ready_a === 1'b0) else begin errors++; $error("FAIL reset_in_ready got %b exp 0", in_ready_a); end
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        #1;
        checks++;
        assert (in_ready_a === 1'b1) else begin errors++; $error("FAIL post_reset_in_ready got %b exp 1", in_ready_a); end

        // ---------------- All-zero message ----------------
        g_a = rand208();
        m = '{16'h0, 16'h0, 16'h0, 16'h0};
        send_frame(1'b0, m, acc0);
        idle(1'b0);
        check_frame(1'b0, m, 208'd0, "zero", cf, cl);
        checks++;
        assert (cf === acc0) else begin errors++; $error("FAIL zero_first_cycle got %0d exp %0d", cf, acc0); end
        checks++;
        assert (cl - acc0 === 16) else begin errors++; $error("FAIL zero_last_cycle got %0d exp 16", cl - acc0); end

        // ---------------- Single 1 in the last bit: parity = g ----------------
        g_a = rand208();
        m = '{16'h0, 16'h0, 16'h0, 16'h0001};
        send_frame(1'b0, m, acc0);
        idle(1'b0);
        check_frame(1'b0, m, g_a, "unit", cf, cl);

        // ---------------- Random data with random stalls ----------------
        rand_a = 1'b1;
        for (int f = 0; f < 3; f++) begin
            g_a = rand208();
            m.delete();
            for (int k = 0; k < 4; k++) m.push_back(16'($urandom));
            send_frame(1'b0, m, acc0);
            idle(1'b0);
            check_frame(1'b0, m, model_rem(m, g_a), "stall", cf, cl);
        end
        rand_a = 1'b0;
        repeat (3) @(negedge clk);

        // ---------------- Reset mid-frame ----------------
        g_a = rand208();
        push(1'b0, 16'hDEAD, dummy);
        push(1'b0, 16'hBEEF, dummy);
        idle(1'b0);
        @(negedge clk);
        rst_n_a = 1'b0;
        @(negedge clk);
        checks++;
        assert (out_valid_a === 1'b0) else begin errors++; $error("FAIL midreset_valid got %b exp 0", out_valid_a); end
        checks++;
        assert (in_ready_a === 1'b0) else begin errors++; $error("FAIL midreset_in_ready got %b exp 0", in_ready_a); end
        rst_n_a = 1'b1;
        q_a.delete();
        m = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        send_frame(1'b0, m, acc0);
        idle(1'b0);
        check_frame(1'b0, m, model_rem(m, g_a), "after_reset", cf, cl);

        // ---------------- Back-to-back frames ----------------
        g_a = rand208();
        m  = '{16'hA5A5, 16'h0F0F, 16'hFFFF, 16'h8001};
        m2 = '{16'h0001, 16'h8000, 16'h3C3C, 16'hC3C3};
        send_frame(1'b0, m, acc0);
        send_frame(1'b0, m2, acc2);
        idle(1'b0);
        check_frame(1'b0, m, model_rem(m, g_a), "b2b_f1", cf, cl);
        check_frame(1'b0, m2, model_rem(m2, g_a), "b2b_f2", cf2, cl2);
        checks++;
        assert (acc2 === cl + 1) else begin errors++; $error("FAIL b2b_accept_cycle got %0d exp %0d", acc2, cl + 1); end
        checks++;
        assert (cf2 === cl + 1) else begin errors++; $error("FAIL b2b_no_gap got %0d exp %0d", cf2, cl + 1); end

        // ---------------- Full-length frame on the 496-word instance ----------------
        g_b = rand208();
        m.delete();
        for (int k = 0; k < 496; k++) m.push_back(16'($urandom));
        send_frame(1'b1, m, acc0);
        idle(1'b1);
        check_frame(1'b1, m, model_rem(m, g_b), "full", cf, cl);
        checks++;
        assert (cl - cf === 508) else begin errors++; $error("FAIL full_span got %0d exp 508", cl - cf); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
